aes_cipher_core: RTL and testbench

AES_CIPHER_CORE -- requirements
Module: aes_cipher_core

---
 rtl/aes_pkg.sv | 32 +++
 rtl/cipherround.sv | 60 ++++++
 rtl/subword.sv | 49 ++++
 rtl/aes_cipher_core.sv | 114 +++++++++++
 tb/tb_aes_cipher_core.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES cipher core:
//   cipherState_t : control FSM state encoding
//   nr()          : number of rounds for a given key length in bits
//   xtime()       : GF(2^8) multiply-by-2 using the AES polynomial 0x11b
// ----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KXRST,
        ARK0,
        ROUND,
        DONE
    } cipherState_t;

    // Round count for the three legal key sizes; anything else falls back to AES-128.
    function automatic int nr(input int keyBits);
        case (keyBits)
            192:     return 12;
            256:     return 14;
            default: return 10;
        endcase
    endfunction

    // Multiply by x in GF(2^8); the reduction folds bit 7 back in as 0x1b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/cipherround.sv
// ----------------------------------------------------------------------------
// cipherround
// One combinational AES encryption round.
// Ports:
//   st        [127:0] : current state, byte 0 in bits [127:120], column-major
//   roundKey  [127:0] : round key to add
//   lastRound         : skip MixColumns (final round)
//   nextSt    [127:0] : AddRoundKey(MixColumns?(ShiftRows(SubBytes(st))))
// ----------------------------------------------------------------------------
module cipherround
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] roundKey,
    input  logic         lastRound,
    output logic [127:0] nextSt
);

    logic [127:0] subbed;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [7:0]   a0, a1, a2, a3;

    // SubBytes: one S-box word per state column.
    for (genvar c = 0; c < 4; c++) begin : g_sub
        subword u_subword (
            .word   (st[127-32*c -: 32]),
            .result (subbed[127-32*c -: 32])
        );
    end

    // Byte (row r, column c) sits at index 4c+r. ShiftRows rotates row r left
    // by r, so output (r,c) takes input (r,(c+r) mod 4). MixColumns then works
    // column by column, and the last round bypasses it.
    always_comb begin
        shifted = '0;
        mixed   = '0;
        a0      = '0;
        a1      = '0;
        a2      = '0;
        a3      = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] = subbed[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = shifted[127-32*c -: 8];
            a1 = shifted[119-32*c -: 8];
            a2 = shifted[111-32*c -: 8];
            a3 = shifted[103-32*c -: 8];
            mixed[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mixed[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mixed[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mixed[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        nextSt = (lastRound ? shifted : mixed) ^ roundKey;
    end

endmodule

// File: rtl/subword.sv
// ----------------------------------------------------------------------------
// subword
// Combinational AES S-box applied to the four bytes of a 32-bit word.
// Ports:
//   word   [31:0] : input bytes, most significant byte first
//   result [31:0] : substituted bytes, same byte order
// The S-box is computed rather than tabled: multiplicative inverse as b^254
// followed by the standard affine transform.
// ----------------------------------------------------------------------------
module subword
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] result
);

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] shifted;
        acc     = 8'h00;
        shifted = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ shifted;
            shifted = xtime(shifted);
        end
        return acc;
    endfunction

    // Square-and-multiply over the exponent 254 (binary 11111110); 0 maps to 0.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gfMul(inv, inv);
            if (i != 0) inv = gfMul(inv, b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Substitute every byte of the word independently.
    always_comb begin
        result = '0;
        for (int i = 0; i < 4; i++) begin
            result[31-8*i -: 8] = sbox(word[31-8*i -: 8]);
        end
    end

endmodule

// File: rtl/aes_cipher_core.sv
// ----------------------------------------------------------------------------
// aes_cipher_core
// Iterative AES encryption core, one round per clock. Round keys come from an
// external key-expansion block that this core restarts and feeds.
// Parameters:
//   K : key length in bits (128, 192 or 256)
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   start                : request; plaintext and key sampled when accepted
//   plaintext [127:0]    : input block, byte 0 in bits [127:120]
//   key       [K-1:0]    : cipher key
//   roundKey  [127:0]    : current round key from key expansion
//   kx_reset             : holds key expansion at round key 0 while high
//   kx_key    [K-1:0]    : key registered at accept, driven to key expansion
//   busy                 : high from accept until done
//   done                 : one-cycle pulse, ciphertext valid
//   ciphertext [127:0]   : result, held until overwritten by the next block
// ----------------------------------------------------------------------------
module aes_cipher_core #(
    parameter int K = 128
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [127:0]   plaintext,
    input  logic [K-1:0]   key,
    input  logic [127:0]   roundKey,
    output logic           kx_reset,
    output logic [K-1:0]   kx_key,
    output logic           busy,
    output logic           done,
    output logic [127:0]   ciphertext
);

    import aes_pkg::*;

    localparam logic [3:0] NR = 4'(nr(K));

    cipherState_t state;
    logic [3:0]   roundCount;
    logic [127:0] st;
    logic [127:0] roundOut;
    logic         lastRound;

    assign lastRound = (roundCount == NR);

    cipherround u_cipherround (
        .st        (st),
        .roundKey  (roundKey),
        .lastRound (lastRound),
        .nextSt    (roundOut)
    );

    // Control FSM with registered outputs: busy, done and kx_reset are set on
    // the same edge that enters the state they describe. kx_reset stays high
    // in IDLE, KXRST and DONE so key expansion sits on round key 0 (loaded from
    // the fresh kx_key during KXRST) and only starts stepping once ARK0 begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            roundCount <= '0;
            st         <= '0;
            ciphertext <= '0;
            kx_key     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            kx_reset   <= 1'b1;
        end else begin
            done     <= 1'b0;
            busy     <= 1'b0;
            kx_reset <= 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= KXRST;
                        kx_key     <= key;
                        st         <= plaintext;
                        roundCount <= 4'd1;
                        busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                KXRST: begin
                    state    <= ARK0;
                    busy     <= 1'b1;
                    kx_reset <= 1'b0;
                end
                ARK0: begin
                    st       <= st ^ roundKey;
                    state    <= ROUND;
                    busy     <= 1'b1;
                    kx_reset <= 1'b0;
                end
                ROUND: begin
                    if (lastRound) begin
                        ciphertext <= roundOut;
                        state      <= DONE;
                        done       <= 1'b1;
                    end else begin
                        st         <= roundOut;
                        roundCount <= roundCount + 4'd1;
                        busy       <= 1'b1;
                        kx_reset   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_core.sv
// ----------------------------------------------------------------------------
// tb_aes_cipher_core
// Drives an AES-128 and an AES-256 instance of aes_cipher_core. Each instance
// gets a behavioural key-expansion model (own S-box generated by the p/q
// iteration). Expected ciphertexts are known-answer vectors pushed to a queue
// at accept and compared, together with latency, when done is seen.
// ----------------------------------------------------------------------------
module tb_aes_cipher_core;

    localparam logic [127:0] KEY1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [127:0] ct;
        int           acceptEdge;
        int           nr;
    } expItem_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start128, start256;
    logic [127:0] pt128, pt256;
    logic [127:0] key128;
    logic [255:0] key256;
    logic [127:0] rk128, rk256;
    logic         kxr128, kxr256;
    logic [127:0] kxk128;
    logic [255:0] kxk256;
    logic         busy128, busy256;
    logic         done128, done256;
    logic [127:0] ct128, ct256;

    logic [7:0]   sboxTbl [0:255];
    expItem_t     q128[$];
    expItem_t     q256[$];
    int           cyc = 0;
    int           rkIdx128 = 0;
    int           rkIdx256 = 0;
    int           doneCount128 = 0;
    int           doneCount256 = 0;
    int           checkCount = 0;
    int           passCount = 0;

    aes_cipher_core #(.K(128)) dut128 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start128),
        .plaintext  (pt128),
        .key        (key128),
        .roundKey   (rk128),
        .kx_reset   (kxr128),
        .kx_key     (kxk128),
        .busy       (busy128),
        .done       (done128),
        .ciphertext (ct128)
    );

    aes_cipher_core #(.K(256)) dut256 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start256),
        .plaintext  (pt256),
        .key        (key256),
        .roundKey   (rk256),
        .kx_reset   (kxr256),
        .kx_key     (kxk256),
        .busy       (busy256),
        .done       (done256),
        .ciphertext (ct256)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp accepts and measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Build the S-box by walking the multiplicative group with generator 3.
    task automatic buildSbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sboxTbl[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sboxTbl[0] = 8'h63;
    endtask

    function automatic logic [31:0] subWordTb(input logic [31:0] w);
        return {sboxTbl[w[31:24]], sboxTbl[w[23:16]], sboxTbl[w[15:8]], sboxTbl[w[7:0]]};
    endfunction

    // FIPS-197 key schedule; key is left-aligned in 256 bits, nk in words.
    function automatic logic [127:0] roundKeyOf(input logic [255:0] k, input int nk,
                                                input int r);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = k[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subWordTb({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subWordTb(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Key-expansion models: reload round key 0 while kx_reset, else step one.
    always @(posedge clk) begin
        if (kxr128) begin
            rkIdx128 <= 0;
            rk128    <= roundKeyOf({kxk128, 128'h0}, 4, 0);
        end else begin
            rkIdx128 <= (rkIdx128 < 14) ? rkIdx128 + 1 : 14;
            rk128    <= roundKeyOf({kxk128, 128'h0}, 4, (rkIdx128 < 14) ? rkIdx128 + 1 : 14);
        end
    end

    always @(posedge clk) begin
        if (kxr256) begin
            rkIdx256 <= 0;
            rk256    <= roundKeyOf(kxk256, 8, 0);
        end else begin
            rkIdx256 <= (rkIdx256 < 14) ? rkIdx256 + 1 : 14;
            rk256    <= roundKeyOf(kxk256, 8, (rkIdx256 < 14) ? rkIdx256 + 1 : 14);
        end
    end

    // Scoreboard: each done pops the oldest expectation for that instance.
    always @(negedge clk) begin : monitor
        expItem_t e;
        if (done128) begin
            doneCount128++;
            if (q128.size() == 0) begin
                checkOutput("spuriousDone128", 128'(done128), 128'd0);
            end else begin
                e = q128.pop_front();
                checkOutput("ct128", ct128, e.ct);
                checkOutput("latency128", 128'(cyc - e.acceptEdge + 1), 128'(e.nr + 3));
            end
        end
        if (done256) begin
            doneCount256++;
            if (q256.size() == 0) begin
                checkOutput("spuriousDone256", 128'(done256), 128'd0);
            end else begin
                e = q256.pop_front();
                checkOutput("ct256", ct256, e.ct);
                checkOutput("latency256", 128'(cyc - e.acceptEdge + 1), 128'(e.nr + 3));
            end
        end
    end

    // Present one block for a single cycle and record what it must produce.
    task automatic applyStimulus(input bit use256, input logic [127:0] pt,
                                 input logic [255:0] k, input logic [127:0] expCt);
        expItem_t item;
        item.ct         = expCt;
        item.acceptEdge = cyc + 1;
        item.nr         = use256 ? 14 : 10;
        if (use256) begin
            start256 = 1'b1;
            pt256    = pt;
            key256   = k;
            q256.push_back(item);
        end else begin
            start128 = 1'b1;
            pt128    = pt;
            key128   = k[255:128];
            q128.push_back(item);
        end
        stepCycle();
        start128 = 1'b0;
        start256 = 1'b0;
    endtask

    task automatic waitDone(input bit use256);
        for (int i = 0; i < 40; i++) begin
            stepCycle();
            if ((use256 ? done256 : done128) == 1'b1) return;
        end
        checkOutput(use256 ? "timeout256" : "timeout128",
                    128'(use256 ? done256 : done128), 128'd1);
    endtask

    initial begin
        int doneBefore;
        buildSbox();
        start128 = 1'b0;
        start256 = 1'b0;
        pt128    = '0;
        pt256    = '0;
        key128   = '0;
        key256   = '0;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rstBusy128", 128'(busy128), 128'd0);
        checkOutput("rstDone128", 128'(done128), 128'd0);
        checkOutput("rstKxReset128", 128'(kxr128), 128'd1);
        checkOutput("rstCt128", ct128, 128'd0);
        checkOutput("rstKxKey128", kxk128, 128'd0);
        checkOutput("rstBusy256", 128'(busy256), 128'd0);
        checkOutput("rstDone256", 128'(done256), 128'd0);
        checkOutput("rstKxReset256", 128'(kxr256), 128'd1);
        checkOutput("rstCt256", ct256, 128'd0);
        checkOutput("rstKxKey256", kxk256[255:128], 128'd0);
        stepCycle();
        stepCycle();
        reset_n = 1'b1;
        stepCycle();

        // Basic AES-128 known answer.
        applyStimulus(1'b0, PT1, {KEY1, 128'h0}, CT1);
        waitDone(1'b0);
        repeat (3) stepCycle();

        // start hammered and inputs scrambled while busy: must be ignored.
        doneBefore = doneCount128;
        applyStimulus(1'b0, PT1, {KEY1, 128'h0}, CT1);
        for (int i = 1; i <= 12; i++) begin
            checkOutput($sformatf("busyHold_%0d", i), 128'(busy128), 128'd1);
            checkOutput($sformatf("kxKeyHold_%0d", i), kxk128, KEY1);
            checkOutput($sformatf("kxReset_%0d", i), 128'(kxr128), 128'(i == 1));
            start128 = 1'b1;
            pt128    = {$urandom, $urandom, $urandom, $urandom};
            key128   = {$urandom, $urandom, $urandom, $urandom};
            stepCycle();
        end
        start128 = 1'b0;
        checkOutput("doneAtCycle13", 128'(done128), 128'd1);
        checkOutput("busyInDone", 128'(busy128), 128'd0);
        checkOutput("kxResetInDone", 128'(kxr128), 128'd1);
        repeat (4) stepCycle();
        checkOutput("singleDone", 128'(doneCount128), 128'(doneBefore + 1));
        checkOutput("ctHeldIdle", ct128, CT1);

        // Back-to-back: second block accepted in the DONE cycle.
        applyStimulus(1'b0, PT1, {KEY1, 128'h0}, CT1);
        waitDone(1'b0);
        applyStimulus(1'b0, PT2, {KEY2, 128'h0}, CT2);
        checkOutput("ctHeldOnAccept", ct128, CT1);
        waitDone(1'b0);
        repeat (2) stepCycle();

        // Reset in the middle of round 5 abandons the block.
        doneBefore = doneCount128;
        applyStimulus(1'b0, PT1, {KEY1, 128'h0}, CT1);
        repeat (6) stepCycle();
        checkOutput("busyBeforeReset", 128'(busy128), 128'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midRstBusy", 128'(busy128), 128'd0);
        checkOutput("midRstDone", 128'(done128), 128'd0);
        checkOutput("midRstKxReset", 128'(kxr128), 128'd1);
        checkOutput("midRstCt", ct128, 128'd0);
        checkOutput("midRstKxKey", kxk128, 128'd0);
        q128.delete();
        stepCycle();
        stepCycle();
        reset_n = 1'b1;
        repeat (14) stepCycle();
        checkOutput("noDoneAfterReset", 128'(doneCount128), 128'(doneBefore));
        applyStimulus(1'b0, PT1, {KEY1, 128'h0}, CT1);
        waitDone(1'b0);
        repeat (2) stepCycle();

        // AES-256 known answer.
        applyStimulus(1'b1, PT1, KEY256, CT256);
        waitDone(1'b1);
        repeat (3) stepCycle();

        checkOutput("pending128", 128'(q128.size()), 128'd0);
        checkOutput("pending256", 128'(q256.size()), 128'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
